pid_avalon_sequencer: RTL and testbench
=======================================

# pid_avalon_sequencer

Avalon-MM master that drives the PID controller's register slave from the far end of its bus. Loads gains and reference on request. Runs one control step per feedback sample: write Fdb, pulse pid_en, poll pid_cmp, read pid_out. Presents the result as a valid/data stream, so encoder and PWM logic need no software in the loop.

## Interface
Parameters:
- POLL_DELAY, 2: idle bus cycles between the pid_en write and the first pid_cmp poll (1..15).
- MAX_POLLS, 255: pid_cmp polls allowed before a timeout is declared (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  one-cycle request to write kp/ki/kd/ref.
- cfg_kp, cfg_ki, cfg_kd, cfg_ref  in  32 each  values sampled on the cycle cfg_load is accepted.
- cfg_done  out  1  one-cycle pulse after the ref write.
- sample_valid  in  1  one-cycle feedback sample strobe.
- sample_data  in  32  feedback value.
- out_valid  out  1  one-cycle pulse; out_data holds the new pid_out.
- out_data  out  32  last captured pid_out; holds its value between pulses.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky; a pending sample was overwritten.
- timeout  out  1  sticky; MAX_POLLS polls all returned pid_cmp=0.
- clr_status  in  1  clears overrun and timeout. Same-cycle set wins.
- avm_chip_select, avm_write, avm_read  out  1 each  Avalon-MM controls.
- avm_address  out  3  register index: 0 kp, 1 ki, 2 kd, 3 ref, 4 fdb, 5 pid_en, 6 pid_out, 7 pid_cmp.
- avm_write_data  out  32  write data.
- avm_read_data  in  32  slave read data. Fixed latency 1; no waitrequest.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also forces state IDLE, clears pending-sample and pending-cfg, and zeroes all counters.
- Bus rules:
  - avm_write and avm_read are never high together.
  - avm_chip_select is high exactly when one of them is high.
  - Each access lasts one cycle. Back-to-back writes are allowed.
- States:
  - IDLE
  - CFG_WR: 2-bit index, writes addresses 0..3.
  - FDB_WR: address 4, data = latched sample.
  - EN_WR: address 5, data 32'h1.
  - WAIT: POLL_DELAY cycles, bus idle.
  - POLL_RD: read address 7.
  - POLL_CHK: evaluates avm_read_data[0].
  - OUT_RD: read address 6.
  - OUT_CAP: captures pid_out.
- IDLE priority: pending/new cfg first, then pending/new sample.
- POLL_CHK transitions:
  - bit0=1 → OUT_RD.
  - bit0=0 and poll count < MAX_POLLS → POLL_RD.
  - Otherwise → set timeout, go to IDLE; no out_valid.
- OUT_CAP: out_data ← avm_read_data, out_valid=1, next state IDLE.
- sample_valid while busy:
  - Latch into a one-deep pending buffer.
  - If the buffer is already full, overwrite it and set overrun.
- cfg_load while busy: latch values plus a pending flag. A second cfg_load overwrites them; no flag is raised. Serviced at the next IDLE.
- Sample and cfg_load in the same IDLE cycle: cfg runs first. The sample goes pending and does not count as an overrun.
- A pending sample is launched at the edge that leaves OUT_CAP's successor IDLE cycle. There are no idle-bus gaps beyond one IDLE cycle.
- Reset mid-transaction: the bus drops to idle immediately (asynchronous). Configuration is not replayed; the host must reissue cfg_load.

## Timing
Cycle numbering: cycle 0 = sample_valid high while IDLE, no pending cfg.
- Cycle 1: fdb write.
- Cycle 2: pid_en write.
- Cycles 3..2+POLL_DELAY: bus idle.
- Cycle 3+POLL_DELAY: first poll read.
- Cycle 4+POLL_DELAY: POLL_CHK (slave data valid).
- Each failed poll adds 2 cycles.
- After a successful check: OUT_RD next cycle, OUT_CAP the cycle after.
- out_valid in cycle 7+POLL_DELAY+2·(failed polls). Default with one poll: cycle 9.
- Config: cfg_load in cycle 0 → writes in cycles 1..4 → cfg_done in cycle 5.
- Timeout: the timeout flag rises in the cycle after the MAX_POLLS-th POLL_CHK; busy falls the same cycle.

## Test plan
- cfg_load with kp=5, ki=3, kd=1, ref=1000 → writes to addresses 0,1,2,3 in consecutive cycles 1..4 with exact data; cfg_done pulses in cycle 5.
- sample_valid with 0x1F4; slave model returns cmp=1 on the first poll and pid_out=0x1234 → fdb write 0x1F4 in cycle 1, pid_en=1 in cycle 2, out_valid with 0x1234 in cycle 9.
- Slave returns cmp=0 three times, then 1 → four poll reads 2 cycles apart; out_valid in cycle 15.
- MAX_POLLS=4, cmp always 0 → exactly 4 polls, timeout=1, no out_valid, busy=0. clr_status then clears timeout.
- Three samples during one step → second is overwritten by third, overrun=1. Next step uses the third value. cfg_load together with a sample in IDLE → config writes precede the fdb write.
- reset_n asserted mid-POLL_RD → all outputs 0 asynchronously; after release the block stays IDLE until a new strobe.

Source files
------------

// File: rtl/pid_avalon_sequencer_if.sv
// Avalon-MM bus between the PID sequencer (master) and the PID register slave.
// Read data arrives with a fixed latency of one cycle; there is no waitrequest.
interface pid_avalon_sequencer_if;
  logic        avm_chip_select;
  logic        avm_write;
  logic        avm_read;
  logic [2:0]  avm_address;
  logic [31:0] avm_write_data;
  logic [31:0] avm_read_data;

  modport master (
    output avm_chip_select, avm_write, avm_read, avm_address, avm_write_data,
    input  avm_read_data
  );

  modport slave (
    input  avm_chip_select, avm_write, avm_read, avm_address, avm_write_data,
    output avm_read_data
  );
endinterface

// File: rtl/pid_avalon_sequencer.sv
// Avalon-MM master that loads PID gains/reference and runs one control step per
// feedback sample (fdb write, pid_en pulse, pid_cmp poll, pid_out read).
module pid_avalon_sequencer #(
  parameter int POLL_DELAY = 2,
  parameter int MAX_POLLS  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_load,
  input  logic [31:0] cfg_kp,
  input  logic [31:0] cfg_ki,
  input  logic [31:0] cfg_kd,
  input  logic [31:0] cfg_ref,
  output logic        cfg_done,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        overrun,
  output logic        timeout,
  input  logic        clr_status,
  pid_avalon_sequencer_if.master avm
);

  typedef enum logic [3:0] {
    IDLE, CFG_WR, FDB_WR, EN_WR, WAIT, POLL_RD, POLL_CHK, OUT_RD, OUT_CAP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        wait_q, wait_d;
  logic [7:0]        poll_q, poll_d;
  logic              pend_valid_q, pend_valid_d;
  logic [31:0]       pend_data_q, pend_data_d;
  logic              cfg_pend_q, cfg_pend_d;
  logic [3:0][31:0]  cfg_pend_val_q, cfg_pend_val_d;
  logic [3:0][31:0]  cfg_act_q, cfg_act_d;
  logic [31:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              cfg_done_q, cfg_done_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              cs_q, cs_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic [2:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              overrun_set, timeout_set;

  // Bus controls for a state are computed on the transition into it so every
  // Avalon output comes straight from a flop.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wait_d         = wait_q;
    poll_d         = poll_q;
    pend_valid_d   = pend_valid_q;
    pend_data_d    = pend_data_q;
    cfg_pend_d     = cfg_pend_q;
    cfg_pend_val_d = cfg_pend_val_q;
    cfg_act_d      = cfg_act_q;
    out_data_d     = out_data_q;
    out_valid_d    = 1'b0;
    cfg_done_d     = 1'b0;
    write_d        = 1'b0;
    read_d         = 1'b0;
    addr_d         = 3'd0;
    wdata_d        = 32'd0;
    overrun_set    = 1'b0;
    timeout_set    = 1'b0;

    if (state_q != IDLE) begin
      if (sample_valid) begin
        overrun_set  = pend_valid_q;
        pend_valid_d = 1'b1;
        pend_data_d  = sample_data;
      end
      if (cfg_load) begin
        cfg_pend_d     = 1'b1;
        cfg_pend_val_d = {cfg_ref, cfg_kd, cfg_ki, cfg_kp};
      end
    end

    case (state_q)
      IDLE: begin
        if (cfg_load || cfg_pend_q) begin
          cfg_act_d  = cfg_load ? {cfg_ref, cfg_kd, cfg_ki, cfg_kp} : cfg_pend_val_q;
          cfg_pend_d = 1'b0;
          idx_d      = 2'd0;
          state_d    = CFG_WR;
          write_d    = 1'b1;
          addr_d     = 3'd0;
          wdata_d    = cfg_act_d[0];
          if (sample_valid) begin
            overrun_set  = pend_valid_q;
            pend_valid_d = 1'b1;
            pend_data_d  = sample_data;
          end
        end else if (pend_valid_q) begin
          // Oldest sample goes first; a same-cycle strobe refills the buffer.
          state_d      = FDB_WR;
          write_d      = 1'b1;
          addr_d       = 3'd4;
          wdata_d      = pend_data_q;
          pend_valid_d = sample_valid;
          pend_data_d  = sample_data;
        end else if (sample_valid) begin
          state_d = FDB_WR;
          write_d = 1'b1;
          addr_d  = 3'd4;
          wdata_d = sample_data;
        end
      end
      CFG_WR: begin
        if (idx_q == 2'd3) begin
          state_d    = IDLE;
          cfg_done_d = 1'b1;
        end else begin
          idx_d   = idx_q + 2'd1;
          write_d = 1'b1;
          addr_d  = {1'b0, idx_d};
          wdata_d = cfg_act_q[idx_d];
        end
      end
      FDB_WR: begin
        state_d = EN_WR;
        write_d = 1'b1;
        addr_d  = 3'd5;
        wdata_d = 32'h1;
      end
      EN_WR: begin
        state_d = WAIT;
        wait_d  = 4'd0;
        poll_d  = 8'd0;
      end
      WAIT: begin
        if (wait_q == 4'(POLL_DELAY - 1)) begin
          state_d = POLL_RD;
          read_d  = 1'b1;
          addr_d  = 3'd7;
          poll_d  = poll_q + 8'd1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      POLL_RD: state_d = POLL_CHK;
      POLL_CHK: begin
        if (avm.avm_read_data[0]) begin
          state_d = OUT_RD;
          read_d  = 1'b1;
          addr_d  = 3'd6;
        end else if (poll_q < 8'(MAX_POLLS)) begin
          state_d = POLL_RD;
          read_d  = 1'b1;
          addr_d  = 3'd7;
          poll_d  = poll_q + 8'd1;
        end else begin
          state_d     = IDLE;
          timeout_set = 1'b1;
        end
      end
      OUT_RD: state_d = OUT_CAP;
      OUT_CAP: begin
        state_d     = IDLE;
        out_data_d  = avm.avm_read_data;
        out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    cs_d      = write_d | read_d;
    busy_d    = (state_d != IDLE);
    overrun_d = overrun_set | (overrun_q & ~clr_status);
    timeout_d = timeout_set | (timeout_q & ~clr_status);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      wait_q         <= 4'd0;
      poll_q         <= 8'd0;
      pend_valid_q   <= 1'b0;
      pend_data_q    <= 32'd0;
      cfg_pend_q     <= 1'b0;
      cfg_pend_val_q <= '0;
      cfg_act_q      <= '0;
      out_data_q     <= 32'd0;
      out_valid_q    <= 1'b0;
      cfg_done_q     <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      cs_q           <= 1'b0;
      write_q        <= 1'b0;
      read_q         <= 1'b0;
      addr_q         <= 3'd0;
      wdata_q        <= 32'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      wait_q         <= wait_d;
      poll_q         <= poll_d;
      pend_valid_q   <= pend_valid_d;
      pend_data_q    <= pend_data_d;
      cfg_pend_q     <= cfg_pend_d;
      cfg_pend_val_q <= cfg_pend_val_d;
      cfg_act_q      <= cfg_act_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      cfg_done_q     <= cfg_done_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      timeout_q      <= timeout_d;
      cs_q           <= cs_d;
      write_q        <= write_d;
      read_q         <= read_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
    end
  end

  assign cfg_done            = cfg_done_q;
  assign out_valid           = out_valid_q;
  assign out_data            = out_data_q;
  assign busy                = busy_q;
  assign overrun             = overrun_q;
  assign timeout             = timeout_q;
  assign avm.avm_chip_select = cs_q;
  assign avm.avm_write       = write_q;
  assign avm.avm_read        = read_q;
  assign avm.avm_address     = addr_q;
  assign avm.avm_write_data  = wdata_q;

endmodule

// File: tb/tb_pid_avalon_sequencer.sv
// Directed bench for pid_avalon_sequencer with a behavioural PID register slave
// whose pid_cmp answer can be delayed by a chosen number of polls.
module tb_pid_avalon_sequencer;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } acc_t;

  logic        clk;
  logic        reset_n;
  logic        cfg_load;
  logic [31:0] cfg_kp, cfg_ki, cfg_kd, cfg_ref;
  logic        cfg_done;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        busy, overrun, timeout;
  logic        clr_status;

  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          busViol = 0;
  acc_t        busLog[$];
  int          ovCyc[$];
  logic [31:0] ovData[$];
  int          doneCyc[$];
  int          toRise[$];
  int          busyFall[$];
  bit          prevTimeout = 1'b0;
  bit          prevBusy = 1'b0;

  int          failCount = 0;
  bit          cmpAlwaysZero = 1'b0;
  logic [31:0] pidOut = 32'h0;
  int          pollsSeen = 0;
  logic [31:0] regs [0:7];

  pid_avalon_sequencer_if bus ();

  pid_avalon_sequencer #(.POLL_DELAY(2), .MAX_POLLS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_load     (cfg_load),
    .cfg_kp       (cfg_kp),
    .cfg_ki       (cfg_ki),
    .cfg_kd       (cfg_kd),
    .cfg_ref      (cfg_ref),
    .cfg_done     (cfg_done),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .busy         (busy),
    .overrun      (overrun),
    .timeout      (timeout),
    .clr_status   (clr_status),
    .avm          (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PID register slave: one-cycle read latency, pid_cmp held low for failCount polls
  always @(posedge clk) begin
    if (bus.avm_write) begin
      regs[bus.avm_address] <= bus.avm_write_data;
      if (bus.avm_address == 3'd5) pollsSeen <= 0;
    end
    if (bus.avm_read) begin
      case (bus.avm_address)
        3'd7: begin
          bus.avm_read_data <= {31'd0, (!cmpAlwaysZero && pollsSeen >= failCount)};
          pollsSeen <= pollsSeen + 1;
        end
        3'd6:    bus.avm_read_data <= pidOut;
        default: bus.avm_read_data <= regs[bus.avm_address];
      endcase
    end
  end

  // Bus and output event recorder, sampled mid-cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.avm_write || bus.avm_read)
        busLog.push_back('{cyc, bus.avm_write, bus.avm_address, bus.avm_write_data});
      if ((bus.avm_chip_select != (bus.avm_write || bus.avm_read)) || (bus.avm_write && bus.avm_read))
        busViol = busViol + 1;
      if (out_valid) begin
        ovCyc.push_back(cyc);
        ovData.push_back(out_data);
      end
      if (cfg_done) doneCyc.push_back(cyc);
      if (timeout && !prevTimeout) toRise.push_back(cyc);
      if (!busy && prevBusy) busyFall.push_back(cyc);
      prevTimeout = timeout;
      prevBusy = busy;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [31:0] sd, input logic cl,
                               input logic [31:0] kp, input logic [31:0] ki,
                               input logic [31:0] kd, input logic [31:0] rf,
                               input logic clr);
    sample_valid = sv;
    sample_data  = sd;
    cfg_load     = cl;
    cfg_kp       = kp;
    cfg_ki       = ki;
    cfg_kd       = kd;
    cfg_ref      = rf;
    clr_status   = clr;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    cfg_load     = 1'b0;
    clr_status   = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic acc_t entryAt(input int i);
    acc_t e;
    e = '{-1, 1'b0, 3'd0, 32'd0};
    if (i >= 0 && i < busLog.size()) e = busLog[i];
    return e;
  endfunction

  function automatic int lastOf(input int q[$]);
    if (q.size() == 0) return -1;
    return q[q.size() - 1];
  endfunction

  function automatic int countAcc(input int base, input bit wr, input logic [2:0] addr);
    int n = 0;
    for (int i = base; i < busLog.size(); i++)
      if (busLog[i].wr == wr && busLog[i].addr == addr) n++;
    return n;
  endfunction

  function automatic int nthAccCyc(input int base, input bit wr, input logic [2:0] addr, input int nth);
    int n = 0;
    for (int i = base; i < busLog.size(); i++)
      if (busLog[i].wr == wr && busLog[i].addr == addr) begin
        if (n == nth) return busLog[i].cyc;
        n++;
      end
    return -1;
  endfunction

  function automatic logic [31:0] nthAccData(input int base, input logic [2:0] addr, input int nth);
    int n = 0;
    for (int i = base; i < busLog.size(); i++)
      if (busLog[i].wr && busLog[i].addr == addr) begin
        if (n == nth) return busLog[i].data;
        n++;
      end
    return 32'hDEAD_BEEF;
  endfunction

  initial begin
    int t0, b, ov0, dn0;
    logic [31:0] cfgVals [4];
    acc_t e;

    reset_n = 1'b0;
    cfg_load = 1'b0; sample_valid = 1'b0; clr_status = 1'b0;
    sample_data = 32'd0;
    cfg_kp = 32'd0; cfg_ki = 32'd0; cfg_kd = 32'd0; cfg_ref = 32'd0;
    bus.avm_read_data = 32'd0;
    for (int i = 0; i < 8; i++) regs[i] = 32'd0;

    #12;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cs", {31'd0, bus.avm_chip_select}, 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] config load");
    cfgVals[0] = 32'd5; cfgVals[1] = 32'd3; cfgVals[2] = 32'd1; cfgVals[3] = 32'd1000;
    b = busLog.size(); dn0 = doneCyc.size(); t0 = cyc;
    applyStimulus(1'b0, 32'd0, 1'b1, cfgVals[0], cfgVals[1], cfgVals[2], cfgVals[3], 1'b0);
    idleCycles(10);
    checkOutput("cfg_nacc", busLog.size() - b, 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = entryAt(b + i);
      checkOutput("cfg_cyc", e.cyc, t0 + 1 + i);
      checkOutput("cfg_wr", {31'd0, e.wr}, 32'd1);
      checkOutput("cfg_addr", {29'd0, e.addr}, i);
      checkOutput("cfg_data", e.data, cfgVals[i]);
    end
    checkOutput("cfg_done_n", doneCyc.size() - dn0, 32'd1);
    checkOutput("cfg_done_cyc", lastOf(doneCyc), t0 + 5);

    $display("[TB] single step, first poll succeeds");
    failCount = 0; pidOut = 32'h1234;
    b = busLog.size(); ov0 = ovCyc.size(); t0 = cyc;
    applyStimulus(1'b1, 32'h1F4, 1'b0, 0, 0, 0, 0, 1'b0);
    idleCycles(14);
    checkOutput("s1_fdb_cyc", nthAccCyc(b, 1'b1, 3'd4, 0), t0 + 1);
    checkOutput("s1_fdb_data", nthAccData(b, 3'd4, 0), 32'h1F4);
    checkOutput("s1_en_cyc", nthAccCyc(b, 1'b1, 3'd5, 0), t0 + 2);
    checkOutput("s1_en_data", nthAccData(b, 3'd5, 0), 32'h1);
    checkOutput("s1_poll_cyc", nthAccCyc(b, 1'b0, 3'd7, 0), t0 + 5);
    checkOutput("s1_polls", countAcc(b, 1'b0, 3'd7), 32'd1);
    checkOutput("s1_outrd_cyc", nthAccCyc(b, 1'b0, 3'd6, 0), t0 + 7);
    checkOutput("s1_ov_n", ovCyc.size() - ov0, 32'd1);
    checkOutput("s1_ov_cyc", lastOf(ovCyc), t0 + 9);
    checkOutput("s1_ov_data", ovData[ovData.size() - 1], 32'h1234);
    checkOutput("s1_out_hold", out_data, 32'h1234);

    $display("[TB] three failed polls");
    failCount = 3; pidOut = 32'h0000_BEEF;
    b = busLog.size(); ov0 = ovCyc.size(); t0 = cyc;
    applyStimulus(1'b1, 32'h77, 1'b0, 0, 0, 0, 0, 1'b0);
    idleCycles(22);
    checkOutput("s3_polls", countAcc(b, 1'b0, 3'd7), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("s3_poll_cyc", nthAccCyc(b, 1'b0, 3'd7, i), t0 + 5 + 2 * i);
    checkOutput("s3_ov_cyc", lastOf(ovCyc), t0 + 15);
    checkOutput("s3_ov_data", ovData[ovData.size() - 1], 32'hBEEF);

    $display("[TB] timeout");
    cmpAlwaysZero = 1'b1;
    b = busLog.size(); ov0 = ovCyc.size(); t0 = cyc;
    applyStimulus(1'b1, 32'h99, 1'b0, 0, 0, 0, 0, 1'b0);
    idleCycles(20);
    checkOutput("to_polls", countAcc(b, 1'b0, 3'd7), 32'd4);
    checkOutput("to_no_ov", ovCyc.size() - ov0, 32'd0);
    checkOutput("to_rise_cyc", lastOf(toRise), t0 + 13);
    checkOutput("to_busy_fall", lastOf(busyFall), t0 + 13);
    checkOutput("to_flag", {31'd0, timeout}, 32'd1);
    checkOutput("to_busy", {31'd0, busy}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("to_cleared", {31'd0, timeout}, 32'd0);
    cmpAlwaysZero = 1'b0;
    failCount = 0;

    $display("[TB] overrun");
    pidOut = 32'h5555;
    b = busLog.size(); ov0 = ovCyc.size(); t0 = cyc;
    applyStimulus(1'b1, 32'hA1, 1'b0, 0, 0, 0, 0, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 32'hB2, 1'b0, 0, 0, 0, 0, 1'b0);
    applyStimulus(1'b1, 32'hC3, 1'b0, 0, 0, 0, 0, 1'b0);
    checkOutput("ovr_flag", {31'd0, overrun}, 32'd1);
    idleCycles(26);
    checkOutput("ovr_fdb_n", countAcc(b, 1'b1, 3'd4), 32'd2);
    checkOutput("ovr_fdb0", nthAccData(b, 3'd4, 0), 32'hA1);
    checkOutput("ovr_fdb1", nthAccData(b, 3'd4, 1), 32'hC3);
    checkOutput("ovr_fdb1_cyc", nthAccCyc(b, 1'b1, 3'd4, 1), t0 + 10);
    checkOutput("ovr_ov_n", ovCyc.size() - ov0, 32'd2);
    checkOutput("ovr_ov_cyc", lastOf(ovCyc), t0 + 18);
    applyStimulus(1'b0, 32'd0, 1'b0, 0, 0, 0, 0, 1'b1);
    checkOutput("ovr_cleared", {31'd0, overrun}, 32'd0);

    $display("[TB] cfg and sample in same idle cycle");
    b = busLog.size(); dn0 = doneCyc.size(); t0 = cyc;
    applyStimulus(1'b1, 32'h55, 1'b1, 32'd7, 32'd8, 32'd9, 32'd10, 1'b0);
    idleCycles(18);
    e = entryAt(b);
    checkOutput("cs_first_addr", {29'd0, e.addr}, 32'd0);
    checkOutput("cs_first_cyc", e.cyc, t0 + 1);
    e = entryAt(b + 3);
    checkOutput("cs_ref_data", e.data, 32'd10);
    checkOutput("cs_ref_cyc", e.cyc, t0 + 4);
    e = entryAt(b + 4);
    checkOutput("cs_fdb_addr", {29'd0, e.addr}, 32'd4);
    checkOutput("cs_fdb_data", e.data, 32'h55);
    checkOutput("cs_fdb_cyc", e.cyc, t0 + 6);
    checkOutput("cs_done_cyc", lastOf(doneCyc), t0 + 5);
    checkOutput("cs_no_overrun", {31'd0, overrun}, 32'd0);

    $display("[TB] reset during poll read");
    t0 = cyc;
    applyStimulus(1'b1, 32'h66, 1'b0, 0, 0, 0, 0, 1'b0);
    idleCycles(4);
    checkOutput("pre_rst_read", {31'd0, bus.avm_read}, 32'd1);
    checkOutput("pre_rst_addr", {29'd0, bus.avm_address}, 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_cs", {31'd0, bus.avm_chip_select}, 32'd0);
    checkOutput("arst_read", {31'd0, bus.avm_read}, 32'd0);
    checkOutput("arst_addr", {29'd0, bus.avm_address}, 32'd0);
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_out_data", out_data, 32'd0);
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;
    b = busLog.size();
    idleCycles(20);
    checkOutput("post_rst_nacc", busLog.size() - b, 32'd0);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);

    checkOutput("bus_rules", busViol, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
